sb_lsosc_div: RTL and testbench
===============================

# sb_lsosc_div

Parametrised multi-channel divided-clock generator for the low-speed oscillator domain. It takes the oscillator clock and produces `NCH` independently programmable, glitch-free gated output clocks. Each channel's enable takes effect only at a low-phase boundary, and its divide value is applied only at period boundaries. It sits directly behind the LSOSC model and feeds low-rate timers and wake-up logic.

## Interface
Parameters:
- `NCH`, default 2: number of output channels, range 1..8.
- `DW`, default 8: width of each half-period count.
- `LOCK_CYCLES`, default 4: number of full output periods before `LOCK[i]` asserts. Used only with `SB_LSOSC_DIV_LOCK_EN`.

Ports:
- `CLK`, in, 1: oscillator clock; all logic is on its rising edge.
- `RST`, in, 1: reset; synchronous, active-high.
- `ENA`, in, NCH: per-channel run request, level-sensitive.
- `DIV`, in, NCH*DW: half-period count `H[i]` = `DIV[i*DW +: DW]`. A value of 0 is treated as 1.
- `CLKOUT`, out, NCH: divided clock, registered.
- `TICK`, out, NCH: one-cycle pulse in the first cycle of each `CLKOUT` high phase.
- `RUN`, out, NCH: channel is not idle.
- `LOCK`, out, NCH: present only with `SB_LSOSC_DIV_LOCK_EN`.

## Operation
- `ENA` is registered once per channel into `ena_q`. All decisions use `ena_q`.
- Each channel has a per-channel FSM with states IDLE, HIGH and LOW. Each channel also has a `DW`-bit counter `cnt` and a latched half-period `h_q`.
- IDLE: `CLKOUT`=0 and `cnt`=0.
  - If `ena_q`=1: latch `h_q` from `DIV` (0 becomes 1), then go to HIGH.
- HIGH: `CLKOUT`=1 and `cnt` increments.
  - When `cnt`==`h_q`-1: clear `cnt` and go to LOW. This transition is unconditional, so a high phase is never truncated.
- LOW: `CLKOUT`=0 and `cnt` increments.
  - When `cnt`==`h_q`-1 and `ena_q`=1: clear `cnt`, re-latch `h_q` from the current `DIV`, and go to HIGH.
  - When `cnt`==`h_q`-1 and `ena_q`=0: go to IDLE.
- Output period is 2·`h_q` CLK cycles with 50% duty. Every high and low phase lasts exactly `h_q` cycles.
- Changing `DIV` mid-period has no effect until the next HIGH entry. The counter never wraps past `h_q`-1. `DIV` at its maximum gives `h_q`=2^DW-1.
- Deasserting `ENA` during HIGH: the current period completes in full, then the channel goes IDLE.
- Deasserting `ENA` during LOW and reasserting it before the end of LOW: no gap. The channel continues into HIGH.
- `TICK[i]`=1 exactly in cycles where the FSM has just entered HIGH.
- `RUN[i]` = (state != IDLE).
- Channels are fully independent and share only `CLK` and `RST`.

## Timing
- Reset values: `CLKOUT`=0, `TICK`=0, `RUN`=0, `LOCK`=0. All FSMs are IDLE, `cnt`=0, `h_q`=1, `ena_q`=0.
- `RST` overrides everything in the same edge, including mid-phase. The output drops to 0 on the edge after `RST` is sampled high.
- Start latency: `ENA` first sampled high at edge k gives `CLKOUT`=1 and `TICK`=1 after edge k+1.
- Stop: the last falling edge of `CLKOUT` occurs exactly at the normal HIGH→LOW point.
  - `RUN` drops `h_q` cycles later, at the end of the LOW phase.
- `h_q`=1 produces a CLK/2 output with a `TICK` every 2 cycles.

## Configuration
- `SB_LSOSC_DIV_LOCK_EN` defined:
  - Each channel has a 4-bit period counter, incremented on each HIGH entry and saturating at `LOCK_CYCLES`.
  - `LOCK[i]` asserts in the cycle after the counter reaches `LOCK_CYCLES` and stays high while the channel runs.
  - Going IDLE, or a `DIV` value different from `h_q` being latched, clears the counter and `LOCK[i]` in the same edge.
- Not defined: the `LOCK` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `sb_lsosc_div_pkg`: the state enum (IDLE/HIGH/LOW) and the lock-counter width constant.
- Sub-module `sb_lsosc_div_ch`: one channel, containing `ena_q`, FSM, `cnt`, `h_q` and the optional lock counter.
- Top level: instantiates `NCH` copies of `sb_lsosc_div_ch` in a generate loop and slices `DIV`.

## Test plan
- Reset check: `RST` high for 3 cycles with `ENA`=all 1. Then: all outputs 0 during and after the reset edge, and channel 0 `CLKOUT` rises 2 edges after `RST` is released.
- Divide ratio: `DIV[0]`=3 with `ENA[0]` held high. Then: `CLKOUT[0]` is 3 high / 3 low repeatedly, with one `TICK` every 6 cycles. `DIV[0]`=0 gives a period of 2.
- Mid-period change: `DIV`=4, switched to 2 during a HIGH phase. Then: the current period stays 4/4 and the next period is 2/2.
- Glitch-free stop: `ENA` dropped in cycle 1 of a high phase with `DIV`=5. Then: `CLKOUT` stays high for 5 cycles total, goes low, and `RUN` drops 5 cycles later.
- Low-phase re-enable: `ENA` pulsed low for 2 cycles inside a LOW phase with `DIV`=4. Then: the period is unaffected and `RUN` stays high.
- Lock (macro on, `LOCK_CYCLES`=4, `DIV`=2): `LOCK` rises the cycle after the 4th `TICK`. Changing `DIV` to 3 clears `LOCK` at the next HIGH entry, and `LOCK` re-asserts after 4 more periods.

Source files
------------

// File: rtl/sb_lsosc_div_pkg.sv
// Shared types for the LSOSC divided-clock generator: channel FSM states and the
// lock period-counter width (used only when SB_LSOSC_DIV_LOCK_EN is defined).
package sb_lsosc_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam int LOCK_CW = 4;

endpackage

// File: rtl/sb_lsosc_div_ch.sv
// One divided-clock channel: registered enable, IDLE/HIGH/LOW FSM, half-period
// counter and latched divide. Optional lock tracking under SB_LSOSC_DIV_LOCK_EN.
module sb_lsosc_div_ch
    import sb_lsosc_div_pkg::*;
#(
    parameter int DW          = 8,
    parameter int LOCK_CYCLES = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ena,
    input  logic [DW-1:0] i_div,
    output logic          o_clkout,
    output logic          o_tick,
`ifdef SB_LSOSC_DIV_LOCK_EN
    output logic          o_lock,
`endif
    output logic          o_run
);

    logic          r_ena_q;
    state_t        r_state;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_h_q;
    logic          r_tick;

    logic [DW-1:0] w_div_eff;
    logic          w_phase_end;

    // A programmed half-period of zero behaves as one.
    assign w_div_eff   = (i_div == '0) ? DW'(1) : i_div;
    assign w_phase_end = (r_cnt == (r_h_q - DW'(1)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ena_q <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_h_q   <= DW'(1);
            r_tick  <= 1'b0;
        end else begin
            r_ena_q <= i_ena;
            r_tick  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_ena_q) begin
                        r_h_q   <= w_div_eff;
                        r_state <= ST_HIGH;
                        r_tick  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    // High phase always runs to completion, regardless of enable.
                    if (w_phase_end) begin
                        r_cnt   <= '0;
                        r_state <= ST_LOW;
                    end else begin
                        r_cnt <= r_cnt + DW'(1);
                    end
                end
                ST_LOW: begin
                    if (w_phase_end) begin
                        r_cnt <= '0;
                        if (r_ena_q) begin
                            r_h_q   <= w_div_eff;
                            r_state <= ST_HIGH;
                            r_tick  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + DW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_clkout = (r_state == ST_HIGH);
    assign o_tick   = r_tick;
    assign o_run    = (r_state != ST_IDLE);

`ifdef SB_LSOSC_DIV_LOCK_EN
    localparam logic [LOCK_CW-1:0] LC = LOCK_CW'(LOCK_CYCLES);

    logic [LOCK_CW-1:0] r_pcnt;
    logic               r_lock;
    logic               w_high_entry;
    logic               w_div_change;
    logic               w_go_idle;

    assign w_high_entry = ((r_state == ST_IDLE) && r_ena_q) ||
                          ((r_state == ST_LOW) && w_phase_end && r_ena_q);
    // Only a re-latch from LOW can change the divide of a running clock.
    assign w_div_change = (r_state == ST_LOW) && w_phase_end && r_ena_q &&
                          (w_div_eff != r_h_q);
    assign w_go_idle    = (r_state == ST_LOW) && w_phase_end && !r_ena_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_go_idle || w_div_change) begin
            r_pcnt <= '0;
            r_lock <= 1'b0;
        end else begin
            if (w_high_entry && (r_pcnt != LC)) begin
                r_pcnt <= r_pcnt + LOCK_CW'(1);
            end
            r_lock <= (r_pcnt == LC);
        end
    end

    assign o_lock = r_lock;
`endif

endmodule

// File: rtl/sb_lsosc_div.sv
// Multi-channel glitch-free divided-clock generator for the LSOSC domain.
// Define SB_LSOSC_DIV_LOCK_EN to add the per-channel LOCK output.
module sb_lsosc_div
    import sb_lsosc_div_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int DW          = 8,
    parameter int LOCK_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NCH-1:0]    ENA,
    input  logic [NCH*DW-1:0] DIV,
    output logic [NCH-1:0]    CLKOUT,
    output logic [NCH-1:0]    TICK,
`ifdef SB_LSOSC_DIV_LOCK_EN
    output logic [NCH-1:0]    LOCK,
`endif
    output logic [NCH-1:0]    RUN
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        sb_lsosc_div_ch #(
            .DW          (DW),
            .LOCK_CYCLES (LOCK_CYCLES)
        ) u_ch (
            .i_clk    (CLK),
            .i_rst    (RST),
            .i_ena    (ENA[g]),
            .i_div    (DIV[g*DW +: DW]),
            .o_clkout (CLKOUT[g]),
            .o_tick   (TICK[g]),
`ifdef SB_LSOSC_DIV_LOCK_EN
            .o_lock   (LOCK[g]),
`endif
            .o_run    (RUN[g])
        );
    end

endmodule

// File: tb/tb_sb_lsosc_div.sv
// Scoreboard bench for sb_lsosc_div: directed per-cycle waveforms on channel 0,
// channel 1 held idle; LOCK vectors apply when SB_LSOSC_DIV_LOCK_EN is defined.
module tb_sb_lsosc_div;

    localparam int NCH = 2;
    localparam int DW  = 8;

    logic              CLK;
    logic              RST;
    logic [NCH-1:0]    ENA;
    logic [NCH*DW-1:0] DIV;
    logic [NCH-1:0]    CLKOUT;
    logic [NCH-1:0]    TICK;
    logic [NCH-1:0]    RUN;
`ifdef SB_LSOSC_DIV_LOCK_EN
    logic [NCH-1:0]    LOCK;
`endif

    sb_lsosc_div #(.NCH(NCH), .DW(DW), .LOCK_CYCLES(4)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .ENA    (ENA),
        .DIV    (DIV),
        .CLKOUT (CLKOUT),
        .TICK   (TICK),
`ifdef SB_LSOSC_DIV_LOCK_EN
        .LOCK   (LOCK),
`endif
        .RUN    (RUN)
    );

    typedef struct {
        int         cyc;
        int         idx;
        string      nm;
        logic [5:0] exp;
        logic [1:0] lexp;
    } item_t;

    item_t sb[$];
    int    cyc      = 0;
    int    checks   = 0;
    int    failures = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc++;

    item_t      mon_it;
    logic [5:0] mon_act;
    logic       mon_ok;

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_it = sb.pop_front();
            checks++;
            if (mon_it.cyc != cyc) begin
                failures++;
                $display("FAIL %s[%0d] expectation for cycle %0d not sampled (now %0d)",
                         mon_it.nm, mon_it.idx, mon_it.cyc, cyc);
            end else begin
                mon_act = {CLKOUT, TICK, RUN};
                mon_ok  = (mon_act === mon_it.exp);
`ifdef SB_LSOSC_DIV_LOCK_EN
                mon_ok  = mon_ok && (LOCK === mon_it.lexp);
                if (!mon_ok) begin
                    failures++;
                    $display("FAIL %s[%0d] clkout/tick/run actual=%b required=%b lock actual=%b required=%b",
                             mon_it.nm, mon_it.idx, mon_act, mon_it.exp, LOCK, mon_it.lexp);
                end
`else
                if (!mon_ok) begin
                    failures++;
                    $display("FAIL %s[%0d] clkout/tick/run actual=%b required=%b",
                             mon_it.nm, mon_it.idx, mon_act, mon_it.exp);
                end
`endif
            end
        end
    end

    // One cycle per character: inputs applied for the next edge, expected outputs after it.
    task automatic run_test(input string nm, input int nrst, input string e, input string d,
                            input string c, input string t, input string u, input string l);
        item_t it;
        logic  eb;
        for (int j = 0; j < c.len(); j++) begin
            eb  = (e[j] == "1");
            RST = (j < nrst);
            ENA = {(j < nrst) ? eb : 1'b0, eb};
            DIV = {8'h07, 8'(d[j] - 8'h30)};
            it.cyc  = cyc + 1;
            it.idx  = j;
            it.nm   = nm;
            it.exp  = {1'b0, c[j] == "1", 1'b0, t[j] == "1", 1'b0, u[j] == "1"};
            it.lexp = {1'b0, (l.len() > j) ? (l[j] == "1") : 1'b0};
            sb.push_back(it);
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        RST = 1'b1;
        ENA = '0;
        DIV = '0;

        run_test("reset", 3, "11111111", "11111111",
                 "00001010", "00001010", "00001111", "");
        run_test("div3", 1, "1111111111111111", "3333333333333333",
                 "0011100011100011", "0010000010000010", "0011111111111111", "");
        run_test("div0", 1, "11111111", "00000000",
                 "00101010", "00101010", "00111111", "");
        run_test("midchg", 1, "1111111111111111", "4442222222222222",
                 "0011110000110011", "0010000000100010", "0011111111111111", "");
        run_test("stop", 1, "111000000000000", "555555555555555",
                 "001111100000000", "001000000000000", "001111111111000", "");
        run_test("lowreen", 1, "111111100111111111", "444444444444444444",
                 "001111000011110000", "001000000010000000", "001111111111111111", "");
`ifdef SB_LSOSC_DIV_LOCK_EN
        run_test("lock", 1,
                 "1111111111111111111111111111111111111111111111",
                 "2222222222222222333333333333333333333333333333",
                 "0011001100110011001110001110001110001110001110",
                 "0010001000100010001000001000001000001000001000",
                 "0011111111111111111111111111111111111111111111",
                 "0000000000000001110000000000000000000000000111");
`endif

        repeat (4) @(posedge CLK);
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain %0d expectations left unchecked, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
